// File: rtl/adder_if_pkg.sv
// rtl/adder_if_pkg.sv - shared width default and operand/sum types for the adder bridge
package adder_if_pkg;

  localparam int WIDTH_DEF = 4;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
  } operands_t;

  typedef logic [WIDTH_DEF:0] sum_t;

endpackage

// File: rtl/adder_core.sv
// rtl/adder_core.sv - combinational unsigned adder, carry kept in the result MSB
module adder_core
  import adder_if_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_if_bridge.sv
// rtl/adder_if_bridge.sv - one-deep registered valid/ready bridge presenting a+b with echoed operands
module adder_if_bridge
  import adder_if_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [WIDTH-1:0] m_a,
  input  logic [WIDTH-1:0] m_b,
  output logic             s_valid,
  input  logic             s_ready,
  output logic [WIDTH-1:0] s_a,
  output logic [WIDTH-1:0] s_b,
  output logic [WIDTH:0]   s_sum,
  output logic             s_carry,
  output logic [15:0]      txn_count
);

  logic [WIDTH:0]   core_sum;
  logic             accept;
  logic             consume;

  logic             s_valid_q, s_valid_d;
  logic [WIDTH-1:0] s_a_q, s_a_d;
  logic [WIDTH-1:0] s_b_q, s_b_d;
  logic [WIDTH:0]   s_sum_q, s_sum_d;
  logic [15:0]      txn_count_q, txn_count_d;

  adder_core #(.WIDTH(WIDTH)) u_adder_core (
    .a   (m_a),
    .b   (m_b),
    .sum (core_sum)
  );

  assign m_ready = !s_valid_q || s_ready;
  assign accept  = m_valid && m_ready;
  assign consume = s_valid_q && s_ready;

  // Operands are only captured on accept, so idle-bus garbage never reaches the slave port.
  always_comb begin
    s_valid_d   = s_valid_q;
    s_a_d       = s_a_q;
    s_b_d       = s_b_q;
    s_sum_d     = s_sum_q;
    txn_count_d = txn_count_q + {15'd0, consume};
    if (accept) begin
      s_valid_d = 1'b1;
      s_a_d     = m_a;
      s_b_d     = m_b;
      s_sum_d   = core_sum;
    end else if (consume) begin
      s_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_q   <= 1'b0;
      s_a_q       <= '0;
      s_b_q       <= '0;
      s_sum_q     <= '0;
      txn_count_q <= '0;
    end else begin
      s_valid_q   <= s_valid_d;
      s_a_q       <= s_a_d;
      s_b_q       <= s_b_d;
      s_sum_q     <= s_sum_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign s_valid   = s_valid_q;
  assign s_a       = s_a_q;
  assign s_b       = s_b_q;
  assign s_sum     = s_sum_q;
  assign s_carry   = s_sum_q[WIDTH];
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_adder_if_bridge.sv
// tb/tb_adder_if_bridge.sv - randomized and directed checks of adder_if_bridge against a queue model
module tb_adder_if_bridge;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_a;
  logic [W-1:0] s_b;
  logic [W:0]   s_sum;
  logic         s_carry;
  logic [15:0]  txn_count;

  int checks   = 0;
  int failures = 0;

  // Pending results: each entry is {a, b}; the front is what the slave port must show.
  int exp_q_a[$];
  int exp_q_b[$];
  int exp_count = 0;
  int consumed  = 0;

  always #5 clk = ~clk;

  adder_if_bridge #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_a       (m_a),
    .m_b       (m_b),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_a       (s_a),
    .s_b       (s_b),
    .s_sum     (s_sum),
    .s_carry   (s_carry),
    .txn_count (txn_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("s_valid", {31'd0, s_valid}, (exp_q_a.size() != 0) ? 32'd1 : 32'd0);
    if (exp_q_a.size() != 0) begin
      int sum;
      sum = exp_q_a[0] + exp_q_b[0];
      check("s_a", {28'd0, s_a}, exp_q_a[0]);
      check("s_b", {28'd0, s_b}, exp_q_b[0]);
      check("s_sum", {27'd0, s_sum}, sum);
      check("s_carry", {31'd0, s_carry}, (sum >= 16) ? 32'd1 : 32'd0);
    end
    check("txn_count", {16'd0, txn_count}, exp_count % 65536);
  endtask

  // Called at a negedge: drive inputs, predict the handshake, clock once, check at next negedge.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
    bit held, acc, con;
    m_valid = v;
    m_a     = a;
    m_b     = b;
    s_ready = r;
    #1;
    held = exp_q_a.size() != 0;
    acc  = v && (!held || r);
    con  = held && r;
    check("m_ready", {31'd0, m_ready}, (!held || r) ? 32'd1 : 32'd0);
    @(posedge clk);
    if (con) begin
      void'(exp_q_a.pop_front());
      void'(exp_q_b.pop_front());
      exp_count++;
      consumed++;
    end
    if (acc) begin
      exp_q_a.push_back(int'(a));
      exp_q_b.push_back(int'(b));
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_valid = 1'($urandom);
      m_a     = W'($urandom);
      m_b     = W'($urandom);
      s_ready = 1'($urandom);
      @(negedge clk);
      check("rst_s_valid", {31'd0, s_valid}, 32'd0);
      check("rst_s_sum", {27'd0, s_sum}, 32'd0);
      check("rst_txn_count", {16'd0, txn_count}, 32'd0);
    end
    exp_q_a.delete();
    exp_q_b.delete();
    exp_count = 0;
    m_valid   = 1'b0;
    s_ready   = 1'b0;
    rst_n     = 1'b1;
    #1;
    check("rst_m_ready", {31'd0, m_ready}, 32'd1);
    @(negedge clk);
  endtask

  logic [W-1:0] dir_a   [6] = '{4'b1010, 4'b1100, 4'b0110, 4'b1001, 4'b1111, 4'b1111};
  logic [W-1:0] dir_b   [6] = '{4'b0101, 4'b0011, 4'b0010, 4'b0001, 4'b0001, 4'b1111};
  logic [W:0]   dir_sum [6] = '{5'b01111, 5'b01111, 5'b01000, 5'b01010, 5'b10000, 5'b11110};

  initial begin
    int sent, budget;
    rst_n   = 1'b0;
    m_valid = 1'b0;
    m_a     = '0;
    m_b     = '0;
    s_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed sums and overflow, streamed back to back.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, dir_a[i], dir_b[i], 1'b1);
      check("dir_sum", {27'd0, s_sum}, {27'd0, dir_sum[i]});
      check("dir_carry", {31'd0, s_carry}, {31'd0, dir_sum[i][W]});
    end
    step(1'b0, 4'd0, 4'd0, 1'b1);

    // Backpressure: hold 0011+0100 for four cycles while new offers are refused.
    step(1'b1, 4'b0011, 4'b0100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, W'($urandom), W'($urandom), 1'b0);
      check("hold_sum", {27'd0, s_sum}, 32'h07);
    end
    step(1'b1, 4'b0101, 4'b0110, 1'b1);
    check("bp_next_sum", {27'd0, s_sum}, 32'h0B);
    step(1'b0, 4'd0, 4'd0, 1'b1);

    // Random streaming of 20 pairs from a fresh reset.
    do_reset();
    consumed = 0;
    sent     = 0;
    budget   = 0;
    while ((sent < 20 || exp_q_a.size() != 0) && budget < 1000) begin
      bit v, r;
      bit will_accept;
      v = (sent < 20) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 2) != 0);
      will_accept = v && (exp_q_a.size() == 0 || r);
      step(v, W'($urandom), W'($urandom), r);
      if (will_accept) sent++;
      budget++;
    end
    check("stream_done", (budget < 1000) ? 32'd1 : 32'd0, 32'd1);
    check("stream_consumed", consumed, 32'd20);
    check("stream_txn_count", {16'd0, txn_count}, 32'd20);

    // Asynchronous reset while a result is held.
    step(1'b1, 4'b1001, 4'b1001, 1'b0);
    check("pre_rst_valid", {31'd0, s_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_s_valid", {31'd0, s_valid}, 32'd0);
    check("async_s_sum", {27'd0, s_sum}, 32'd0);
    check("async_txn_count", {16'd0, txn_count}, 32'd0);
    check("async_m_ready", {31'd0, m_ready}, 32'd1);
    @(negedge clk);
    do_reset();
    step(1'b1, 4'b0111, 4'b1000, 1'b1);
    check("post_rst_sum", {27'd0, s_sum}, 32'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
